// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter.
//   READ_FLAG / WRITE_FLAG : transfer direction encoding on *_rw signals
//   FETCH_SIZE             : byte count used for every instruction fetch
//   arb_state_e            : arbiter FSM state (2-bit)
package mem_req_arbiter_pkg;

    localparam logic       READ_FLAG  = 1'b0;
    localparam logic       WRITE_FLAG = 1'b1;
    localparam logic [2:0] FETCH_SIZE = 3'd4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2,
        ARB_DRAIN   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Saturating counter with synchronous clear, used to age a waiting fetch.
// Only built when MEM_ARB_AGING_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global ready; low freezes the count
//   clr        : clear to 0 (wins over inc)
//   inc        : count up, saturating at LIMIT
//   at_limit   : count has reached LIMIT
`ifdef MEM_ARB_AGING_EN
module mem_arb_age_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam int            W   = $clog2(LIMIT + 1);
    localparam logic [W-1:0]  MAX = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (clr)
                cnt <= '0;
            else if (inc && cnt != MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == MAX);
endmodule
`endif

// File: rtl/mem_req_arbiter.sv
// Shares the byte-serial memory controller between the instruction fetcher
// and the LSU. One downstream transaction at a time; LSU has priority.
// Speculative reads are squashed on drop_in; stores always complete.
// Optional feature: define MEM_ARB_AGING_EN to force a waiting fetch through
// after AGE_LIMIT consecutive LSU grants.
// Ports:
//   clk_in, rst_n_in         : clock, asynchronous active-low reset
//   rdy_in                   : global ready, low freezes all state
//   drop_in                  : pipeline rollback pulse
//   if_en_in/if_pc_in        : fetch request
//   if_ok_out/if_inst_out    : fetch completion pulse and instruction
//   ls_en_in/ls_rw_in/ls_addr_in/ls_size_in/ls_wdata_in : LSU request
//   ls_ok_out/ls_rdata_out   : LSU completion pulse and load data
//   mem_*_out                : downstream request, held until mem_ok_in
//   mem_ok_in/mem_rdata_in   : downstream completion and read data
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef MEM_ARB_AGING_EN
    ,
    parameter int AGE_LIMIT = 4
`endif
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              drop_in,
    input  logic              if_en_in,
    input  logic [ADDR_W-1:0] if_pc_in,
    output logic              if_ok_out,
    output logic [DATA_W-1:0] if_inst_out,
    input  logic              ls_en_in,
    input  logic              ls_rw_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [2:0]        ls_size_in,
    input  logic [DATA_W-1:0] ls_wdata_in,
    output logic              ls_ok_out,
    output logic [DATA_W-1:0] ls_rdata_out,
    output logic              mem_en_out,
    output logic              mem_rw_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [2:0]        mem_size_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic              mem_ok_in,
    input  logic [DATA_W-1:0] mem_rdata_in
);

    arb_state_e state;
    logic       ok_pending;
    logic       grant_ls;
    logic       grant_if;
    logic       fetch_first;
    logic       squash;

    // While an ok pulse is on the wire the requester is still deasserting en,
    // so no grant is made in that cycle.
    assign ok_pending = if_ok_out | ls_ok_out;

    // Only reads are speculative; a store in flight is never squashed.
    assign squash = drop_in &&
                    ((state == ARB_BUSY_IF) ||
                     (state == ARB_BUSY_LS && mem_rw_out == READ_FLAG));

`ifdef MEM_ARB_AGING_EN
    logic age_inc;
    logic age_clr;

    // Count only LSU grants that overtake a waiting fetch.
    assign age_inc = grant_ls & if_en_in;
    assign age_clr = grant_if | drop_in | (grant_ls & ~if_en_in);

    mem_arb_age_ctr #(
        .LIMIT(AGE_LIMIT)
    ) u_age_ctr (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .en      (rdy_in),
        .clr     (age_clr),
        .inc     (age_inc),
        .at_limit(fetch_first)
    );
`else
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        // NOTE: both flags get a default before any branch, so no path leaves them unassigned and no latch is inferred.
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (rdy_in && state == ARB_IDLE && !drop_in && !ok_pending) begin
            if (if_en_in && (fetch_first || !ls_en_in))
                grant_if = 1'b1;
            else if (ls_en_in)
                grant_ls = 1'b1;
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= ARB_IDLE;
            if_ok_out     <= 1'b0;
            ls_ok_out     <= 1'b0;
            if_inst_out   <= '0;
            ls_rdata_out  <= '0;
            mem_en_out    <= 1'b0;
            mem_rw_out    <= READ_FLAG;
            mem_addr_out  <= '0;
            mem_size_out  <= '0;
            mem_wdata_out <= '0;
        end else if (rdy_in) begin
            if_ok_out <= 1'b0;
            ls_ok_out <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (grant_ls) begin
                        state         <= ARB_BUSY_LS;
                        mem_en_out    <= 1'b1;
                        mem_rw_out    <= ls_rw_in;
                        mem_addr_out  <= ls_addr_in;
                        mem_size_out  <= ls_size_in;
                        mem_wdata_out <= ls_wdata_in;
                    end else if (grant_if) begin
                        state         <= ARB_BUSY_IF;
                        mem_en_out    <= 1'b1;
                        mem_rw_out    <= READ_FLAG;
                        mem_addr_out  <= if_pc_in;
                        mem_size_out  <= FETCH_SIZE;
                        mem_wdata_out <= '0;
                    end
                end
                ARB_BUSY_IF, ARB_BUSY_LS: begin
                    if (mem_ok_in) begin
                        state      <= ARB_IDLE;
                        mem_en_out <= 1'b0;
                        if (!squash) begin
                            if (state == ARB_BUSY_IF) begin
                                if_inst_out <= mem_rdata_in;
                                if_ok_out   <= 1'b1;
                            end else begin
                                ls_rdata_out <= mem_rdata_in;
                                ls_ok_out    <= 1'b1;
                            end
                        end
                    end else if (squash) begin
                        state <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    // Downstream cannot be aborted; wait it out and discard the data.
                    if (mem_ok_in) begin
                        state      <= ARB_IDLE;
                        mem_en_out <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: table-driven single transactions,
// hand-written multi-cycle sequences (priority, drop, freeze, starvation,
// async reset) and randomized rounds against a transaction-level model.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int AGE_LIMIT_TB = 4;
`ifdef MEM_ARB_AGING_EN
    localparam int LS_BURST            = 10;
    localparam int EXP_LS_BEFORE_FETCH = 4;
`else
    localparam int LS_BURST            = 6;
    localparam int EXP_LS_BEFORE_FETCH = 6;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        drop_in;
    logic        if_en_in;
    logic [31:0] if_pc_in;
    logic        if_ok_out;
    logic [31:0] if_inst_out;
    logic        ls_en_in;
    logic        ls_rw_in;
    logic [31:0] ls_addr_in;
    logic [2:0]  ls_size_in;
    logic [31:0] ls_wdata_in;
    logic        ls_ok_out;
    logic [31:0] ls_rdata_out;
    logic        mem_en_out;
    logic        mem_rw_out;
    logic [31:0] mem_addr_out;
    logic [2:0]  mem_size_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ok_in;
    logic [31:0] mem_rdata_in;

    always #5 clk_in = ~clk_in;

    mem_req_arbiter dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .drop_in      (drop_in),
        .if_en_in     (if_en_in),
        .if_pc_in     (if_pc_in),
        .if_ok_out    (if_ok_out),
        .if_inst_out  (if_inst_out),
        .ls_en_in     (ls_en_in),
        .ls_rw_in     (ls_rw_in),
        .ls_addr_in   (ls_addr_in),
        .ls_size_in   (ls_size_in),
        .ls_wdata_in  (ls_wdata_in),
        .ls_ok_out    (ls_ok_out),
        .ls_rdata_out (ls_rdata_out),
        .mem_en_out   (mem_en_out),
        .mem_rw_out   (mem_rw_out),
        .mem_addr_out (mem_addr_out),
        .mem_size_out (mem_size_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_ok_in    (mem_ok_in),
        .mem_rdata_in (mem_rdata_in)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int age_model = 0;

    typedef struct {
        bit          is_fetch;
        logic        rw;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic [2:0]  exp_size;
        logic        exp_rw;
    } vec_t;

    vec_t       vecs [7];
    logic [2:0] size_tab [4] = '{3'd1, 3'd2, 3'd4, 3'd3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) at negedges for mem_en_out; cycles = negedges waited.
    task automatic wait_mem_en(input string name, output int cycles);
        cycles = 0;
        while (mem_en_out !== 1'b1 && cycles < 20) begin
            @(negedge clk_in);
            cycles++;
        end
        check({name, "_granted"}, 32'(mem_en_out), 32'd1);
    endtask

    // Downstream model: hold for lat cycles (plus optional rdy_in stall), then pulse ok.
    // Returns at the negedge where the arbiter's ok pulse is visible.
    task automatic serve(input int lat, input logic [31:0] rdata, input int stalls);
        logic [31:0] a0;
        bit          held;
        a0   = mem_addr_out;
        held = 1'b1;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk_in);
            held &= (mem_en_out === 1'b1) && (mem_addr_out === a0);
        end
        if (stalls > 0) begin
            rdy_in = 1'b0;
            repeat (stalls) @(negedge clk_in);
            rdy_in = 1'b1;
            held &= (mem_en_out === 1'b1) && (mem_addr_out === a0);
        end
        check("serve_req_held", 32'(held), 32'd1);
        mem_ok_in    = 1'b1;
        mem_rdata_in = rdata;
        @(negedge clk_in);
        mem_ok_in    = 1'b0;
        mem_rdata_in = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        if (v.is_fetch) begin
            if_pc_in = v.addr;
            if_en_in = 1'b1;
        end else begin
            ls_rw_in    = v.rw;
            ls_addr_in  = v.addr;
            ls_size_in  = v.size;
            ls_wdata_in = v.wdata;
            ls_en_in    = 1'b1;
        end
        wait_mem_en(tag, cyc);
        check({tag, "_grant_latency"}, 32'(cyc), 32'd1);
        check({tag, "_addr"}, mem_addr_out, v.addr);
        check({tag, "_rw"}, 32'(mem_rw_out), 32'(v.exp_rw));
        check({tag, "_size"}, 32'(mem_size_out), 32'(v.exp_size));
        if (v.exp_rw == WRITE_FLAG)
            check({tag, "_wdata"}, mem_wdata_out, v.wdata);
        serve(v.lat, v.rdata, 0);
        if (v.is_fetch) begin
            check({tag, "_if_ok"}, 32'(if_ok_out), 32'd1);
            check({tag, "_if_inst"}, if_inst_out, v.rdata);
            check({tag, "_ls_ok_quiet"}, 32'(ls_ok_out), 32'd0);
            if_en_in = 1'b0;
        end else begin
            check({tag, "_ls_ok"}, 32'(ls_ok_out), 32'd1);
            check({tag, "_if_ok_quiet"}, 32'(if_ok_out), 32'd0);
            if (v.exp_rw == READ_FLAG)
                check({tag, "_ls_rdata"}, ls_rdata_out, v.rdata);
            ls_en_in = 1'b0;
        end
        @(negedge clk_in);
        check({tag, "_ok_single_pulse"}, 32'({if_ok_out, ls_ok_out}), 32'd0);
        check({tag, "_mem_released"}, 32'(mem_en_out), 32'd0);
    endtask

    // Transaction-level model of the arbitration rule.
    function automatic bit model_pick_fetch(bit f, bit l);
        if (!l) return 1'b1;
        if (!f) return 1'b0;
`ifdef MEM_ARB_AGING_EN
        if (age_model >= AGE_LIMIT_TB) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void model_grant(bit fetch, bit fetch_waiting);
        if (fetch || !fetch_waiting) age_model = 0;
        else if (age_model < AGE_LIMIT_TB) age_model++;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        int ls_done;
        bit fetch_seen;

        vecs[0] = '{1'b1, READ_FLAG,  32'h0000_0100, 3'd0, 32'h0,         5, 32'h00A0_0093, 3'd4, READ_FLAG};
        vecs[1] = '{1'b0, READ_FLAG,  32'h0000_2000, 3'd4, 32'h0,         3, 32'h1122_3344, 3'd4, READ_FLAG};
        vecs[2] = '{1'b0, READ_FLAG,  32'h0000_2001, 3'd1, 32'h0,         1, 32'h0000_00AB, 3'd1, READ_FLAG};
        vecs[3] = '{1'b0, READ_FLAG,  32'h0000_2002, 3'd2, 32'h0,         2, 32'h0000_BEEF, 3'd2, READ_FLAG};
        vecs[4] = '{1'b0, WRITE_FLAG, 32'h0003_0000, 3'd4, 32'hDEAD_BEEF, 4, 32'h0,         3'd4, WRITE_FLAG};
        vecs[5] = '{1'b0, WRITE_FLAG, 32'h0003_0005, 3'd7, 32'h0000_00CC, 2, 32'h0,         3'd7, WRITE_FLAG};
        vecs[6] = '{1'b1, READ_FLAG,  32'hFFFF_FFFC, 3'd0, 32'h0,         1, 32'hFFFF_FFFF, 3'd4, READ_FLAG};

        rst_n_in = 1'b0; rdy_in = 1'b1; drop_in = 1'b0;
        if_en_in = 1'b0; if_pc_in = '0;
        ls_en_in = 1'b0; ls_rw_in = READ_FLAG; ls_addr_in = '0; ls_size_in = '0; ls_wdata_in = '0;
        mem_ok_in = 1'b0; mem_rdata_in = '0;

        // Reset values
        repeat (2) @(negedge clk_in);
        check("rst_ok", 32'({if_ok_out, ls_ok_out}), 32'd0);
        check("rst_mem_en", 32'(mem_en_out), 32'd0);
        check("rst_mem_rw", 32'(mem_rw_out), 32'(READ_FLAG));
        check("rst_mem_addr", mem_addr_out, 32'd0);
        check("rst_data", if_inst_out | ls_rdata_out | mem_wdata_out, 32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        check("idle_no_req", 32'(mem_en_out), 32'd0);

        // Table-driven single transactions
        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: LSU first, fetch the cycle after ls_ok_out
        if_pc_in = 32'h104; if_en_in = 1'b1;
        ls_rw_in = READ_FLAG; ls_addr_in = 32'h2000; ls_size_in = 3'd4; ls_en_in = 1'b1;
        wait_mem_en("tie", cyc);
        check("tie_lsu_first", mem_addr_out, 32'h2000);
        serve(2, 32'hCAFE_F00D, 0);
        check("tie_ls_ok", 32'(ls_ok_out), 32'd1);
        check("tie_ls_rdata", ls_rdata_out, 32'hCAFE_F00D);
        ls_en_in = 1'b0;
        @(negedge clk_in);
        check("tie_no_grant_in_ok_cycle", 32'(mem_en_out), 32'd0);
        @(negedge clk_in);
        check("tie_fetch_en", 32'(mem_en_out), 32'd1);
        check("tie_fetch_addr", mem_addr_out, 32'h104);
        serve(1, 32'h0000_0013, 0);
        check("tie_if_ok", 32'(if_ok_out), 32'd1);
        if_en_in = 1'b0;
        @(negedge clk_in);

        // Drop during fetch: drain, no ok, then a clean fetch
        if_pc_in = 32'h100; if_en_in = 1'b1;
        wait_mem_en("drop_if", cyc);
        @(negedge clk_in);
        drop_in = 1'b1; if_en_in = 1'b0;
        @(negedge clk_in);
        drop_in = 1'b0;
        check("drain_holds_en", 32'(mem_en_out), 32'd1);
        check("drain_holds_addr", mem_addr_out, 32'h100);
        if_pc_in = 32'h200; if_en_in = 1'b1;
        @(negedge clk_in);
        check("drain_no_new_grant", mem_addr_out, 32'h100);
        mem_ok_in = 1'b1; mem_rdata_in = 32'h1234_5678;
        @(negedge clk_in);
        mem_ok_in = 1'b0; mem_rdata_in = '0;
        check("drain_no_if_ok", 32'(if_ok_out), 32'd0);
        check("drain_released", 32'(mem_en_out), 32'd0);
        wait_mem_en("after_drain", cyc);
        check("after_drain_latency", 32'(cyc), 32'd1);
        check("after_drain_addr", mem_addr_out, 32'h200);
        serve(2, 32'h0000_0293, 0);
        check("after_drain_if_ok", 32'(if_ok_out), 32'd1);
        check("after_drain_inst", if_inst_out, 32'h0000_0293);
        if_en_in = 1'b0;
        @(negedge clk_in);

        // Drop on the same cycle as mem_ok_in for an LSU read
        ls_rw_in = READ_FLAG; ls_addr_in = 32'h2400; ls_size_in = 3'd4; ls_en_in = 1'b1;
        wait_mem_en("drop_ok_same", cyc);
        drop_in = 1'b1; mem_ok_in = 1'b1; mem_rdata_in = 32'h5555_AAAA; ls_en_in = 1'b0;
        @(negedge clk_in);
        drop_in = 1'b0; mem_ok_in = 1'b0; mem_rdata_in = '0;
        check("drop_ok_same_no_ls_ok", 32'(ls_ok_out), 32'd0);
        check("drop_ok_same_idle", 32'(mem_en_out), 32'd0);

        // Drop in IDLE blocks the grant for that cycle only
        ls_rw_in = READ_FLAG; ls_addr_in = 32'h2800; ls_en_in = 1'b1; drop_in = 1'b1;
        @(negedge clk_in);
        drop_in = 1'b0;
        check("drop_idle_no_grant", 32'(mem_en_out), 32'd0);
        wait_mem_en("drop_idle_retry", cyc);
        check("drop_idle_retry_latency", 32'(cyc), 32'd1);
        serve(1, 32'h0000_0042, 0);
        check("drop_idle_ls_ok", 32'(ls_ok_out), 32'd1);
        ls_en_in = 1'b0;
        @(negedge clk_in);

        // Store survives a drop
        ls_rw_in = WRITE_FLAG; ls_addr_in = 32'h30000; ls_size_in = 3'd4; ls_wdata_in = 32'hDEAD_BEEF;
        ls_en_in = 1'b1;
        wait_mem_en("store_drop", cyc);
        @(negedge clk_in);
        drop_in = 1'b1;
        @(negedge clk_in);
        drop_in = 1'b0;
        check("store_drop_en", 32'(mem_en_out), 32'd1);
        check("store_drop_rw", 32'(mem_rw_out), 32'(WRITE_FLAG));
        check("store_drop_addr", mem_addr_out, 32'h30000);
        check("store_drop_wdata", mem_wdata_out, 32'hDEAD_BEEF);
        serve(2, 32'h0, 0);
        check("store_drop_ls_ok", 32'(ls_ok_out), 32'd1);
        ls_en_in = 1'b0;
        @(negedge clk_in);
        check("store_drop_single", 32'(ls_ok_out), 32'd0);

        // rdy_in low: no grant, mem_ok_in ignored
        ls_rw_in = READ_FLAG; ls_addr_in = 32'h2C00; ls_en_in = 1'b1; rdy_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("frozen_no_grant", 32'(mem_en_out), 32'd0);
        rdy_in = 1'b1;
        wait_mem_en("unfrozen", cyc);
        check("unfrozen_latency", 32'(cyc), 32'd1);
        rdy_in = 1'b0; mem_ok_in = 1'b1; mem_rdata_in = 32'h0000_0BAD;
        @(negedge clk_in);
        mem_ok_in = 1'b0; mem_rdata_in = '0;
        @(negedge clk_in);
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("frozen_ok_ignored_en", 32'(mem_en_out), 32'd1);
        check("frozen_ok_ignored_ok", 32'(ls_ok_out), 32'd0);
        serve(1, 32'h0000_0055, 0);
        check("frozen_then_ok", 32'(ls_ok_out), 32'd1);
        check("frozen_then_data", ls_rdata_out, 32'h0000_0055);
        ls_en_in = 1'b0;
        @(negedge clk_in);

        // LSU back-to-back with fetch waiting
        if_pc_in = 32'h400; if_en_in = 1'b1;
        ls_rw_in = READ_FLAG; ls_addr_in = 32'h5000; ls_size_in = 3'd4; ls_en_in = 1'b1;
        ls_done = 0; fetch_seen = 1'b0;
        for (int t = 0; t < 16 && !fetch_seen; t++) begin
            wait_mem_en("burst", cyc);
            if (mem_addr_out == 32'h400) fetch_seen = 1'b1;
            serve(1, 32'h0, 0);
            if (ls_ok_out) begin
                ls_done++;
                if (ls_done == LS_BURST) ls_en_in = 1'b0;
            end
        end
        ls_en_in = 1'b0; if_en_in = 1'b0;
        check("burst_fetch_served", 32'(fetch_seen), 32'd1);
        check("burst_ls_before_fetch", 32'(ls_done), 32'(EXP_LS_BEFORE_FETCH));
        @(negedge clk_in);

        // Asynchronous reset in BUSY_LS
        ls_rw_in = READ_FLAG; ls_addr_in = 32'h3000; ls_en_in = 1'b1;
        wait_mem_en("arst", cyc);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_ctrl", 32'({mem_en_out, mem_rw_out, if_ok_out, ls_ok_out, mem_size_out}), 32'd0);
        check("arst_addr", mem_addr_out, 32'd0);
        check("arst_data", if_inst_out | ls_rdata_out | mem_wdata_out, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1; ls_en_in = 1'b0;
        @(negedge clk_in);
        check("arst_idle", 32'(mem_en_out), 32'd0);
        run_vec(vecs[0], "post_reset");

        // Randomized rounds against the transaction-level model
        age_model = 0;
        for (int r = 0; r < 40; r++) begin
            bit          f;
            bit          l;
            bit          pick_f;
            logic [31:0] pc;
            logic [31:0] la;
            logic        lrw;
            logic [2:0]  sz;
            logic [31:0] wd;
            logic [31:0] rd;
            f   = ($urandom_range(1) == 1);
            l   = ($urandom_range(1) == 1);
            if (!f && !l) f = 1'b1;
            pc  = $urandom & 32'hFFFF_FFFC;
            la  = $urandom;
            lrw = ($urandom_range(1) == 1);
            sz  = size_tab[$urandom_range(3)];
            wd  = $urandom;
            if_pc_in = pc; if_en_in = f;
            ls_addr_in = la; ls_rw_in = lrw; ls_size_in = sz; ls_wdata_in = wd; ls_en_in = l;
            while (f || l) begin
                pick_f = model_pick_fetch(f, l);
                model_grant(pick_f, f);
                wait_mem_en("rnd", cyc);
                check("rnd_addr", mem_addr_out, pick_f ? pc : la);
                check("rnd_rw", 32'(mem_rw_out), 32'(pick_f ? READ_FLAG : lrw));
                check("rnd_size", 32'(mem_size_out), 32'(pick_f ? 3'd4 : sz));
                if (!pick_f && lrw == WRITE_FLAG)
                    check("rnd_wdata", mem_wdata_out, wd);
                rd = $urandom;
                serve($urandom_range(5, 1), rd, $urandom_range(2));
                if (pick_f) begin
                    check("rnd_if_ok", 32'({if_ok_out, ls_ok_out}), 32'd2);
                    check("rnd_if_inst", if_inst_out, rd);
                    if_en_in = 1'b0;
                    f = 1'b0;
                end else begin
                    check("rnd_ls_ok", 32'({if_ok_out, ls_ok_out}), 32'd1);
                    if (lrw == READ_FLAG)
                        check("rnd_ls_rdata", ls_rdata_out, rd);
                    ls_en_in = 1'b0;
                    l = 1'b0;
                end
            end
            @(negedge clk_in);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
